wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the write-back stage has priority; multi-cycle
// results wait in a 2-entry FIFO and, after four consecutive losses, stall the pipe for one grant.
module wb_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_regwrite,
  input  logic        WB_memtoreg,
  input  logic [31:0] WB_rdata,
  input  logic [31:0] WB_out,
  input  logic [2:0]  WB_rd,
  input  logic        MD_valid,
  input  logic [2:0]  MD_rd,
  input  logic [31:0] MD_result,
  output logic        MD_ready,
  output logic        RF_we,
  output logic [2:0]  RF_waddr,
  output logic [31:0] RF_wdata,
  output logic        pipe_stall
);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  age_q, age_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [2:0]  fifo_rd_q [2];
  logic [2:0]  fifo_rd_d [2];
  logic [31:0] fifo_data_q [2];
  logic [31:0] fifo_data_d [2];
  logic        rf_we_q, rf_we_d;
  logic [2:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        pipe_stall_q, pipe_stall_d;
  logic        push, pop;

  assign MD_ready   = (count_q != 2'd2);
  assign RF_we      = rf_we_q;
  assign RF_waddr   = rf_waddr_q;
  assign RF_wdata   = rf_wdata_q;
  assign pipe_stall = pipe_stall_q;

  always_comb begin
    push        = MD_valid && MD_ready;
    pop         = 1'b0;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;

    if (state_q == FORCE) begin
      pop = (count_q != 2'd0);
    end else if (WB_regwrite) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = WB_rd;
      rf_wdata_d = WB_memtoreg ? WB_rdata : WB_out;
    end else if (count_q != 2'd0) begin
      pop = 1'b1;
    end

    if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end

    if (push) begin
      fifo_rd_d[wr_ptr_q]   = MD_rd;
      fifo_data_d[wr_ptr_q] = MD_result;
    end
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};

    state_d = state_q;
    age_d   = age_q;
    case (state_q)
      IDLE: begin
        age_d = 2'd0;
        if (push) state_d = PEND;
      end
      PEND: begin
        if (pop) begin
          age_d = 2'd0;
          if (count_d == 2'd0) state_d = IDLE;
        end else if (age_q == 2'd3) begin
          // fourth consecutive loss: take the port next cycle regardless of WB
          age_d   = 2'd0;
          state_d = FORCE;
        end else begin
          age_d = age_q + 2'd1;
        end
      end
      FORCE: begin
        age_d   = 2'd0;
        state_d = (count_d == 2'd0) ? IDLE : PEND;
      end
      default: begin
        age_d   = 2'd0;
        state_d = IDLE;
      end
    endcase
    pipe_stall_d = (state_d == FORCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      age_q        <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_rd_q    <= '{default: '0};
      fifo_data_q  <= '{default: '0};
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      age_q        <= age_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_data_q  <= fifo_data_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pipe_stall_q <= pipe_stall_d;
    end
  end

endmodule
